// File: rtl/exe_mdu_if.sv
// EX-stage request / MDU response bundle for exe_mdu.
// master = EX pipeline side, slave = the multiply/divide unit.
interface exe_mdu_if #(
  parameter int DATA_W = 32,
  parameter int TRD_W  = 3
);
  logic              start_exe;
  logic [1:0]        op_exe;
  logic              sgn_exe;
  logic [DATA_W-1:0] data_a_exe;
  logic [DATA_W-1:0] data_b_exe;
  logic [TRD_W-1:0]  trd_exe;
  logic [4:0]        reg_wr_exe;
  logic              flushEX;
  logic [TRD_W-1:0]  flush_trd;
  logic              stall_exe;
  logic              busy_mdu;
  logic              done_mdu;
  logic [DATA_W-1:0] result_mdu;
  logic [TRD_W-1:0]  trd_mdu;
  logic [4:0]        reg_wr_mdu;
  logic              dz_mdu;

  modport master (
    output start_exe, op_exe, sgn_exe, data_a_exe, data_b_exe, trd_exe, reg_wr_exe,
           flushEX, flush_trd,
    input  stall_exe, busy_mdu, done_mdu, result_mdu, trd_mdu, reg_wr_mdu, dz_mdu
  );

  modport slave (
    input  start_exe, op_exe, sgn_exe, data_a_exe, data_b_exe, trd_exe, reg_wr_exe,
           flushEX, flush_trd,
    output stall_exe, busy_mdu, done_mdu, result_mdu, trd_mdu, reg_wr_mdu, dz_mdu
  );
endinterface

// File: rtl/exe_mdu.sv
// exe_mdu: iterative radix-2 multiply / restoring divide, one thread-tagged op in flight.
// Divider datapath exists only with MDU_DIV_EN defined; otherwise DIV/REM return 0 with dz set.
module exe_mdu #(
  parameter int DATA_W = 32,
  parameter int TRD_W  = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  exe_mdu_if.slave mdu
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TRD_W-1:0]  trd_q, trd_d;
  logic [4:0]        reg_wr_q, reg_wr_d;
  logic              dz_q, dz_d, done_q, done_d;

  logic              accept, flush_hit, sa, sb, dz_fix;
  logic [DATA_W-1:0] a_mag, b_mag, res_fix;
  logic [DATA_W:0]   mul_sum;
  logic [W2-1:0]     mul_step, calc_step, prod_fix;

  assign sa    = mdu.sgn_exe && mdu.data_a_exe[DATA_W-1];
  assign sb    = mdu.sgn_exe && mdu.data_b_exe[DATA_W-1];
  assign a_mag = sa ? -mdu.data_a_exe : mdu.data_a_exe;
  assign b_mag = sb ? -mdu.data_b_exe : mdu.data_b_exe;

  assign accept    = mdu.start_exe && (state_q == IDLE || state_q == DONE) &&
                     !(mdu.flushEX && (mdu.flush_trd == mdu.trd_exe));
  assign flush_hit = mdu.flushEX && (mdu.flush_trd == trd_q);

  // Multiplier sits in the low half and drains out as partial sums shift in from the top.
  assign mul_sum  = {1'b0, acc_q[W2-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
  logic              nega_q, nega_d, bz_q, bz_d;
  logic [DATA_W:0]   div_sh;
  logic              div_ge;
  logic [DATA_W-1:0] div_rem, quot_fix, rem_fix;

  // Restoring step: remainder in the high half, dividend/quotient in the low half.
  assign div_sh    = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
  assign div_ge    = (div_sh >= {1'b0, opnd_q});
  assign div_rem   = div_sh[DATA_W-1:0] - opnd_q;
  assign calc_step = !op_q[1] ? mul_step :
                     div_ge   ? {div_rem, acc_q[DATA_W-2:0], 1'b1} :
                                {div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};

  // With b==0 the loop leaves quotient all ones and remainder |a|; restoring a's sign gives a back.
  assign quot_fix = (neg_q && !bz_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = nega_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];
  assign dz_fix   = op_q[1] && bz_q;

  always_comb begin
    case (op_q)
      2'd0:    res_fix = prod_fix[DATA_W-1:0];
      2'd1:    res_fix = prod_fix[W2-1:DATA_W];
      2'd2:    res_fix = quot_fix;
      default: res_fix = rem_fix;
    endcase
  end

  always_comb begin
    nega_d = nega_q;
    bz_d   = bz_q;
    if (accept) begin
      nega_d = sa;
      bz_d   = (mdu.data_b_exe == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nega_q <= 1'b0;
      bz_q   <= 1'b0;
    end else begin
      nega_q <= nega_d;
      bz_q   <= bz_d;
    end
  end
`else
  assign calc_step = mul_step;
  assign dz_fix    = op_q[1];
  assign res_fix   = op_q[1] ? '0 : (op_q[0] ? prod_fix[W2-1:DATA_W] : prod_fix[DATA_W-1:0]);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    trd_d    = trd_q;
    reg_wr_d = reg_wr_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      CALC: begin
        if (flush_hit) state_d = IDLE;
        else begin
          acc_d = calc_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flush_hit) state_d = IDLE;
        else begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = res_fix;
          dz_d     = dz_fix;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      op_d     = mdu.op_exe;
      trd_d    = mdu.trd_exe;
      reg_wr_d = mdu.reg_wr_exe;
      neg_d    = sa ^ sb;
      cnt_d    = '0;
      opnd_d   = mdu.op_exe[1] ? b_mag : a_mag;
      acc_d    = {{DATA_W{1'b0}}, (mdu.op_exe[1] ? a_mag : b_mag)};
`ifdef MDU_DIV_EN
      state_d  = CALC;
`else
      state_d  = mdu.op_exe[1] ? FIX : CALC;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      trd_q    <= '0;
      reg_wr_q <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      trd_q    <= trd_d;
      reg_wr_q <= reg_wr_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign mdu.stall_exe  = mdu.start_exe && (state_q == CALC || state_q == FIX);
  assign mdu.busy_mdu   = (state_q != IDLE);
  assign mdu.done_mdu   = done_q;
  assign mdu.result_mdu = result_q;
  assign mdu.trd_mdu    = trd_q;
  assign mdu.reg_wr_mdu = reg_wr_q;
  assign mdu.dz_mdu     = dz_q;
endmodule

// File: tb/tb_exe_mdu.sv
// Scoreboard bench for exe_mdu: expectations queued at issue, popped on done_mdu.
// Expectations follow MDU_DIV_EN the same way as the design.
module tb_exe_mdu;
  localparam int W  = 32;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] trd;
    logic [4:0]    rd;
    logic          dz;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  exe_mdu_if #(.DATA_W(W), .TRD_W(TW)) bus ();
  exe_mdu #(.DATA_W(W), .TRD_W(TW)) dut (.clk(clk), .rst_n(rst_n), .mdu(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] t,
                                 input logic [4:0] r, input int st);
    exp_t e;
    logic [2*W-1:0] p;
    logic signed [W-1:0] as_, bs_;
    e.trd = t; e.rd = r; e.dz = 1'b0; e.due = st + W + 2; e.res = '0;
    as_ = a; bs_ = b;
    if (sg) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    else    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0: e.res = p[W-1:0];
      2'd1: e.res = p[2*W-1:W];
      default: begin
`ifdef MDU_DIV_EN
        if (b == '0) begin
          e.dz  = 1'b1;
          e.res = (op == 2'd2) ? '1 : a;
        end else if (sg && a == {1'b1, {(W-1){1'b0}}} && b == '1) e.res = (op == 2'd2) ? a : '0;
        else if (sg) e.res = (op == 2'd2) ? as_ / bs_ : as_ % bs_;
        else         e.res = (op == 2'd2) ? a / b : a % b;
`else
        e.res = '0; e.dz = 1'b1; e.due = st + 2;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic drive(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t, input logic [4:0] r);
    bus.start_exe = 1'b1; bus.op_exe = op; bus.sgn_exe = sg;
    bus.data_a_exe = a; bus.data_b_exe = b; bus.trd_exe = t; bus.reg_wr_exe = r;
  endtask

  task automatic do_op(input logic [1:0] op, input logic sg, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t, input logic [4:0] r,
                       input bit push, output int st);
    @(negedge clk);
    drive(op, sg, a, b, t, r);
    st = cyc;
    if (push) sb.push_back(model(op, sg, a, b, t, r, st));
    @(posedge clk);
    #1 bus.start_exe = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || bus.busy_mdu) && n < 200);
    chk("drain", {63'd0, (sb.size() == 0 && !bus.busy_mdu)}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done_mdu) begin
      if (sb.size() == 0) chk("spurious_done", {63'd0, bus.done_mdu}, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("result", bus.result_mdu, mon_e.res);
        chk("trd", bus.trd_mdu, mon_e.trd);
        chk("reg_wr", bus.reg_wr_mdu, mon_e.rd);
        chk("dz", bus.dz_mdu, mon_e.dz);
        chk("latency", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, st1, n;
    logic [1:0] rop;
    logic rsg;
    logic [W-1:0] ra, rb;
    bus.start_exe = 1'b0; bus.op_exe = '0; bus.sgn_exe = 1'b0; bus.data_a_exe = '0;
    bus.data_b_exe = '0; bus.trd_exe = '0; bus.reg_wr_exe = '0;
    bus.flushEX = 1'b0; bus.flush_trd = '0;
    repeat (3) @(negedge clk);
    chk("rst0_result", bus.result_mdu, 0);
    chk("rst0_trd", bus.trd_mdu, 0);
    chk("rst0_done", bus.done_mdu, 0);
    chk("rst0_busy", bus.busy_mdu, 0);
    rst_n = 1'b1;

    do_op(2'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 3'd1, 5'd7, 1'b1, st); wait_idle();
    chk("mul_const", bus.result_mdu, 32'hFFFF_FFFE);
    do_op(2'd1, 1'b0, 32'hFFFF_FFFF, 32'd2, 3'd2, 5'd8, 1'b1, st); wait_idle();
    chk("mulh_const", bus.result_mdu, 32'h0000_0001);
`ifdef MDU_DIV_EN
    do_op(2'd2, 1'b1, 32'hFFFF_FFF9, 32'd2, 3'd1, 5'd3, 1'b1, st); wait_idle();
    chk("div_neg", bus.result_mdu, 32'hFFFF_FFFD);
    do_op(2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 3'd1, 5'd3, 1'b1, st); wait_idle();
    chk("rem_neg", bus.result_mdu, 32'hFFFF_FFFF);
    do_op(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 5'd4, 1'b1, st); wait_idle();
    chk("div_ovf", bus.result_mdu, 32'h8000_0000);
    chk("div_ovf_dz", bus.dz_mdu, 0);
    do_op(2'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 5'd4, 1'b1, st); wait_idle();
    chk("rem_ovf", bus.result_mdu, 32'h0);
    do_op(2'd2, 1'b0, 32'd5, 32'd0, 3'd3, 5'd5, 1'b1, st); wait_idle();
    chk("div_dz", bus.result_mdu, 32'hFFFF_FFFF);
    chk("div_dz_flag", bus.dz_mdu, 1);
    do_op(2'd3, 1'b0, 32'd5, 32'd0, 3'd3, 5'd5, 1'b1, st); wait_idle();
    chk("rem_dz", bus.result_mdu, 32'd5);
`else
    do_op(2'd2, 1'b0, 32'd5, 32'd0, 3'd3, 5'd5, 1'b1, st); wait_idle();
    chk("div_off", bus.result_mdu, 32'd0);
    chk("div_off_dz", bus.dz_mdu, 1);
    do_op(2'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 3'd4, 5'd6, 1'b1, st); wait_idle();
    chk("rem_off", bus.result_mdu, 32'd0);
`endif

    for (int i = 0; i < 12; i++) begin
      rop = 2'($urandom_range(0, 3));
      rsg = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 5 == 1) ra = 32'h8000_0000;
      if (i % 3 == 2) rb = $urandom_range(1, 15);
      if (i % 4 == 0) rb = '0;
      do_op(rop, rsg, ra, rb, 3'(i), 5'(i + 10), 1'b1, st); wait_idle();
    end

    // Busy stall, then accept in the DONE cycle of the first op.
    do_op(2'd0, 1'b0, 32'h1234_5678, 32'h9, 3'd1, 5'd3, 1'b1, st1);
    while (cyc < st1 + 5) @(negedge clk);
    drive(2'd0, 1'b1, 32'hFFFF_FFF0, 32'h3, 3'd2, 5'd4);
    #1;
    n = 0;
    while (bus.stall_exe && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", n, 29);
    chk("accept_cycle", cyc, st1 + W + 2);
    sb.push_back(model(2'd0, 1'b1, 32'hFFFF_FFF0, 32'h3, 3'd2, 5'd4, cyc));
    @(posedge clk);
    #1 bus.start_exe = 1'b0;
    wait_idle();

    // Flush of the in-flight thread: no done.
    do_op(2'd0, 1'b1, 32'h0000_0123, 32'hFFFF_FF00, 3'd3, 5'd10, 1'b0, st);
    while (cyc < st + 10) @(negedge clk);
    bus.flushEX = 1'b1; bus.flush_trd = 3'd3;
    @(posedge clk);
    #1 bus.flushEX = 1'b0;
    chk("flush_idle", bus.busy_mdu, 0);
    repeat (W + 4) @(negedge clk);
    chk("flush_quiet", bus.busy_mdu, 0);

    // Flush of another thread is ignored.
    do_op(2'd0, 1'b1, 32'h0000_0123, 32'hFFFF_FF00, 3'd3, 5'd11, 1'b1, st);
    while (cyc < st + 10) @(negedge clk);
    bus.flushEX = 1'b1; bus.flush_trd = 3'd4;
    @(posedge clk);
    #1 bus.flushEX = 1'b0;
    chk("flush_other_busy", bus.busy_mdu, 1);
    wait_idle();

    // Asynchronous reset mid-operation.
    do_op(2'd0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 3'd5, 5'd9, 1'b0, st);
    while (cyc < st + 12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", bus.result_mdu, 0);
    chk("rst_trd", bus.trd_mdu, 0);
    chk("rst_reg", bus.reg_wr_mdu, 0);
    chk("rst_dz", bus.dz_mdu, 0);
    chk("rst_done", bus.done_mdu, 0);
    chk("rst_busy", bus.busy_mdu, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    chk("rst_quiet", bus.busy_mdu, 0);
    do_op(2'd1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0100, 3'd6, 5'd12, 1'b1, st); wait_idle();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
